edge_pulse_generator: RTL and testbench

Multi-channel, parametrised successor to the single-channel falling-edge pulse generator. Each channel takes an asynchronous input and runs it through a synchroniser and a glitch filter. It then detects rising, falling or both edges, selectable per channel at run time. On each qualified edge it emits a stretchable pulse and bumps a saturating edge counter. Sits between external trigger/strobe pins (ADC data-ready, sync lines) and the capture/control logic.

---
 rtl/edge_pulse_generator.sv | 110 +++++++++++
 tb/tb_edge_pulse_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_generator.sv
// Multi-channel edge pulse generator: each channel is synchronised, glitch filtered,
// edge qualified per run-time mode, then drives a stretchable pulse and a saturating edge count.
`timescale 1ns/1ps
module edge_pulse_generator #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int PULSE_CYCLES  = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           in_sig,
  input  logic [2*CHANNELS-1:0]         edge_mode,
  input  logic                          enable,
  input  logic                          count_clr,
  output logic [CHANNELS-1:0]           pulse_out,
  output logic [CHANNELS-1:0]           level_out,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  localparam logic [FW-1:0]        FILT_LAST    = FW'(FILTER_CYCLES - 1);
  localparam logic [PW-1:0]        STRETCH_LOAD = PW'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [FW-1:0]          filt_cnt_reg;
      logic                   level_reg;
      logic [PW-1:0]          stretch_reg;
      logic                   pulse_reg;
      logic [CNT_WIDTH-1:0]   cnt_reg;
      logic                   s;
      logic                   toggle;
      logic                   qualified;
      logic [1:0]             mode;

      assign s    = sync_reg[SYNC_STAGES-1];
      assign mode = edge_mode[2*gi +: 2];

      // Level flips only after the new value has persisted FILTER_CYCLES cycles.
      assign toggle    = (s != level_reg) && (filt_cnt_reg == FILT_LAST);
      assign qualified = enable && toggle &&
                         ((!level_reg && mode[0]) || (level_reg && mode[1]));

      // Idle-high reset value keeps lines that rest high from producing an edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_sig[gi]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          filt_cnt_reg <= '0;
          level_reg    <= 1'b1;
        end else if (s == level_reg) begin
          filt_cnt_reg <= '0;
        end else if (toggle) begin
          filt_cnt_reg <= '0;
          level_reg    <= s;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pulse_reg   <= 1'b0;
          stretch_reg <= '0;
        end else if (!enable) begin
          pulse_reg   <= 1'b0;
          stretch_reg <= '0;
        end else if (qualified) begin
          pulse_reg   <= 1'b1;
          stretch_reg <= STRETCH_LOAD;
        end else if (pulse_reg) begin
          if (stretch_reg == '0) begin
            pulse_reg <= 1'b0;
          end else begin
            stretch_reg <= stretch_reg - PW'(1);
          end
        end
      end

      // A clear coinciding with an edge still records that edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (count_clr) begin
          cnt_reg <= qualified ? CNT_WIDTH'(1) : '0;
        end else if (qualified && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end

      assign pulse_out[gi]                          = pulse_reg;
      assign level_out[gi]                          = level_reg;
      assign edge_count[gi*CNT_WIDTH +: CNT_WIDTH]  = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Directed bench: a per-cycle vector table on a fast-filter instance, plus hand sequences
// for latency, glitch rejection, saturation, enable drop and mid-pulse reset.
`timescale 1ns/1ps
module tb_edge_pulse_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instance A: defaults
  logic        rst_a, en_a, clr_a;
  logic [3:0]  in_a, pulse_a, level_a;
  logic [7:0]  mode_a;
  logic [63:0] cnt_a;
  edge_pulse_generator dut_a (
    .clk(clk), .rst(rst_a), .in_sig(in_a), .edge_mode(mode_a), .enable(en_a),
    .count_clr(clr_a), .pulse_out(pulse_a), .level_out(level_a), .edge_count(cnt_a));

  // Instance B: no filtering, 3-cycle pulse, 4-bit counter
  logic       rst_b, en_b, clr_b;
  logic [0:0] in_b, pulse_b, level_b;
  logic [1:0] mode_b;
  logic [3:0] cnt_b;
  edge_pulse_generator #(.CHANNELS(1), .FILTER_CYCLES(1), .PULSE_CYCLES(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_sig(in_b), .edge_mode(mode_b), .enable(en_b),
    .count_clr(clr_b), .pulse_out(pulse_b), .level_out(level_b), .edge_count(cnt_b));

  // Instance C: two channels, 8-cycle pulse
  logic        rst_c, en_c, clr_c;
  logic [1:0]  in_c, pulse_c, level_c;
  logic [3:0]  mode_c;
  logic [31:0] cnt_c;
  edge_pulse_generator #(.CHANNELS(2), .PULSE_CYCLES(8)) dut_c (
    .clk(clk), .rst(rst_c), .in_sig(in_c), .edge_mode(mode_c), .enable(en_c),
    .count_clr(clr_c), .pulse_out(pulse_c), .level_out(level_c), .edge_count(cnt_c));

  typedef struct {
    logic       in_v;
    logic [1:0] mode;
    logic       en;
    logic       clr;
    logic       exp_lvl;
    logic       exp_pul;
    int         exp_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic i, input logic [1:0] m, input logic e, input logic c,
                     input logic l, input logic p, input int n);
    vec_t r;
    r.in_v = i; r.mode = m; r.en = e; r.clr = c;
    r.exp_lvl = l; r.exp_pul = p; r.exp_cnt = n;
    tbl.push_back(r);
  endtask

  task automatic wait_pulse_c(output bit seen);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); #1;
      if (pulse_c[0]) seen = 1;
    end
  endtask

  initial begin
    int  pcyc;
    bit  lvl_dipped;
    bit  seen;

    rst_a = 1; rst_b = 1; rst_c = 1;
    en_a = 1; en_b = 1; en_c = 1;
    clr_a = 0; clr_b = 0; clr_c = 0;
    in_a = '1; in_b = '1; in_c = '1;
    mode_a = 8'b11_11_11_10; mode_b = 2'b11; mode_c = 4'b10_10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_level", level_a, 4'hF);
    check("rst_a_pulse", pulse_a, 0);
    check("rst_a_count", cnt_a, 0);
    check("rst_b_level", level_b, 1);
    check("rst_c_level", level_c, 2'b11);
    @(negedge clk);
    rst_a = 0; rst_b = 0; rst_c = 0;

    // Vector table for B: level after edge i follows input of row i-2.
    row(1,2'b11,1,0, 1,0,0); row(0,2'b11,1,0, 1,0,0); row(0,2'b11,1,0, 1,0,0);
    row(1,2'b11,1,0, 0,1,1); row(1,2'b11,1,0, 0,1,1); row(1,2'b11,1,0, 1,1,2);
    row(1,2'b11,1,0, 1,1,2); row(1,2'b11,1,0, 1,1,2); row(1,2'b11,1,0, 1,0,2);
    row(0,2'b11,1,0, 1,0,2); row(0,2'b11,1,0, 1,0,2); row(0,2'b11,0,0, 0,0,2);
    row(1,2'b11,1,0, 0,0,2); row(1,2'b11,1,0, 0,0,2); row(1,2'b11,1,0, 1,1,3);
    row(1,2'b11,0,0, 1,0,3); row(1,2'b11,1,0, 1,0,3);
    row(0,2'b01,1,0, 1,0,3); row(0,2'b01,1,0, 1,0,3); row(1,2'b01,1,0, 0,0,3);
    row(1,2'b01,1,0, 0,0,3); row(1,2'b00,1,0, 1,0,3);
    row(0,2'b10,1,0, 1,0,3); row(0,2'b10,1,0, 1,0,3); row(1,2'b10,1,0, 0,1,4);
    row(1,2'b01,1,0, 0,1,4); row(1,2'b01,1,0, 1,1,5); row(1,2'b01,1,0, 1,1,5);
    row(1,2'b01,1,0, 1,1,5); row(1,2'b01,1,0, 1,0,5);
    row(1,2'b11,1,1, 1,0,0); row(0,2'b11,1,0, 1,0,0); row(1,2'b11,1,0, 1,0,0);
    row(1,2'b11,1,1, 0,1,1); row(1,2'b11,1,0, 1,1,2); row(1,2'b11,1,0, 1,1,2);
    row(1,2'b11,1,0, 1,1,2); row(1,2'b11,1,0, 1,0,2);

    for (int i = 0; i < tbl.size(); i++) begin
      in_b = tbl[i].in_v; mode_b = tbl[i].mode; en_b = tbl[i].en; clr_b = tbl[i].clr;
      @(posedge clk); #1;
      check($sformatf("vec%0d_level", i), level_b, tbl[i].exp_lvl);
      check($sformatf("vec%0d_pulse", i), pulse_b, tbl[i].exp_pul);
      check($sformatf("vec%0d_count", i), cnt_b, tbl[i].exp_cnt);
      @(negedge clk);
    end
    en_b = 1; clr_b = 0; mode_b = 2'b11;

    // Saturation: 17 edges into a 4-bit counter
    clr_b = 1; @(negedge clk); clr_b = 0;
    for (int i = 0; i < 17; i++) begin
      in_b = ~in_b;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("sat_count", cnt_b, 15);

    // A: fall on ch0, pulse exactly at edge k+5
    repeat (4) @(negedge clk);
    in_a[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      check($sformatf("lat_pulse_k%0d", j), pulse_a[0], (j == 5) ? 1 : 0);
      check($sformatf("lat_level_k%0d", j), level_a[0], (j >= 5) ? 0 : 1);
    end
    check("lat_count_ch0", cnt_a[15:0], 1);
    check("lat_count_others", cnt_a[63:16], 0);
    @(negedge clk);
    in_a[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("rise_ignored_level", level_a[0], 1);
    check("rise_ignored_count", cnt_a[15:0], 1);

    // A: 3-cycle glitch rejected, then 4-cycle low accepted
    mode_a[1:0] = 2'b11;
    for (int g = 3; g <= 4; g++) begin
      @(negedge clk);
      in_a[0] = 1'b0;
      repeat (g) @(posedge clk);
      @(negedge clk);
      in_a[0] = 1'b1;
      pcyc = 0; lvl_dipped = 0;
      for (int t = 0; t < 16; t++) begin
        @(posedge clk); #1;
        if (pulse_a[0]) pcyc++;
        if (!level_a[0]) lvl_dipped = 1;
      end
      check($sformatf("glitch%0d_pulse_cycles", g), pcyc, (g == 3) ? 0 : 2);
      check($sformatf("glitch%0d_level_dip", g), lvl_dipped, (g == 3) ? 0 : 1);
      check($sformatf("glitch%0d_count", g), cnt_a[15:0], (g == 3) ? 1 : 3);
    end
    check("glitch_other_pulses", pulse_a[3:1], 0);

    // C: enable dropped mid-pulse
    @(negedge clk);
    in_c[0] = 1'b0;
    wait_pulse_c(seen);
    check("en_drop_pulse_seen", seen, 1);
    repeat (2) @(posedge clk);
    #1;
    check("en_drop_pulse_held", pulse_c[0], 1);
    @(negedge clk);
    en_c = 1'b0;
    @(posedge clk); #1;
    check("en_drop_pulse_low", pulse_c[0], 0);
    check("en_drop_level", level_c[0], 0);
    check("en_drop_count", cnt_c[15:0], 1);
    @(negedge clk);
    en_c = 1'b1;
    in_c[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("en_restore_pulse", pulse_c[0], 0);

    // C: reset two cycles into a pulse
    in_c[0] = 1'b0;
    wait_pulse_c(seen);
    check("rst_mid_pulse_seen", seen, 1);
    check("rst_mid_count_before", cnt_c[15:0], 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    in_c[0] = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_pulse", pulse_c, 0);
    check("rst_mid_level", level_c, 2'b11);
    check("rst_mid_count", cnt_c, 0);
    @(negedge clk);
    rst_c = 1'b0;
    pcyc = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (pulse_c != 0) pcyc++;
    end
    check("post_rst_no_pulse", pcyc, 0);
    check("post_rst_level", level_c, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
